// File: rtl/fetch_stage_if.sv
// Bundle for the fetch stage: instruction-memory request/response bus, redirect
// input and the decode-side valid/ready handshake.
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic [2:0]  id_type_o;
    logic        id_illegal_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output id_valid_o, id_pc_o, id_instr_o, id_type_o, id_illegal_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  id_valid_o, id_pc_o, id_instr_o, id_type_o, id_illegal_o,
        output id_ready_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-order imem requests under a credit limit, a
// response FIFO with predecode, and redirect flushing of buffered/in-flight words.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_stage_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] RTYPE = 3'd0;
    localparam logic [2:0] ITYPE = 3'd1;
    localparam logic [2:0] STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4;
    localparam logic [2:0] JTYPE = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  typ;
        logic        ill;
    } entry_t;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rq_rd_q, rq_rd_d, rq_wr_q, rq_wr_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [31:0]   rq_q   [DEPTH];
    logic [31:0]   rq_d   [DEPTH];

    logic [CW:0] credit;
    logic        req, fire, push, pop;
    logic [2:0]  dec_type;
    logic        dec_ill;

    always_comb begin
        dec_type = RTYPE;
        dec_ill  = 1'b0;
        case (bus.imem_rdata_i[6:0])
            7'b0110011, 7'b1010011, 7'b1000011,
            7'b1000111, 7'b1001011, 7'b1001111: dec_type = RTYPE;
            7'b0010011, 7'b0000011, 7'b0000111,
            7'b1100111, 7'b1110011:             dec_type = ITYPE;
            7'b0100011, 7'b0100111:             dec_type = STYPE;
            7'b1100011:                         dec_type = BTYPE;
            7'b0110111, 7'b0010111:             dec_type = UTYPE;
            7'b1101111:                         dec_type = JTYPE;
            default:                            dec_ill  = 1'b1;
        endcase
    end

    // Outstanding requests plus buffered words never exceed DEPTH, so every
    // response always has a FIFO slot and the request-PC queue cannot overflow.
    always_comb begin
        credit = {1'b0, out_q} + {1'b0, cnt_q};
        req    = !rst_i && !bus.redirect_i && (credit < (CW+1)'(DEPTH));
        fire   = req && bus.imem_gnt_i;
        push   = bus.imem_rvalid_i && (drop_q == '0) && !bus.redirect_i;
        pop    = (cnt_q != '0) && bus.id_ready_i && !bus.redirect_i;

        pc_d    = pc_q;
        out_d   = out_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rq_rd_d = rq_rd_q;
        rq_wr_d = rq_wr_q;
        fifo_d  = fifo_q;
        rq_d    = rq_q;

        if (fire) begin
            pc_d          = pc_q + 32'd4;
            rq_d[rq_wr_q] = pc_q;
            rq_wr_d       = rq_wr_q + PW'(1);
        end

        case ({fire, bus.imem_rvalid_i})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        if (bus.imem_rvalid_i) begin
            rq_rd_d = rq_rd_q + PW'(1);
            if (drop_q != '0) drop_d = drop_q - CW'(1);
        end

        if (push) begin
            fifo_d[wr_q] = '{pc: rq_q[rq_rd_q], instr: bus.imem_rdata_i,
                             typ: dec_type, ill: dec_ill};
            wr_d = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Redirect wins: whatever is still in flight after this edge is dropped.
        if (bus.redirect_i) begin
            pc_d   = {bus.redirect_pc_i[31:2], 2'b00};
            drop_d = out_d;
            cnt_d  = '0;
            rd_d   = wr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            rq_rd_q <= '0;
            rq_wr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
                rq_q[i]   <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rq_rd_q <= rq_rd_d;
            rq_wr_q <= rq_wr_d;
            fifo_q  <= fifo_d;
            rq_q    <= rq_d;
        end
    end

    always_comb begin
        bus.imem_req_o   = req;
        bus.imem_addr_o  = pc_q;
        bus.id_valid_o   = (cnt_q != '0);
        bus.id_pc_o      = fifo_q[rd_q].pc;
        bus.id_instr_o   = fifo_q[rd_q].instr;
        bus.id_type_o    = fifo_q[rd_q].typ;
        bus.id_illegal_o = fifo_q[rd_q].ill;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order imem model with optional response
// stall, delivery monitor, and one task per scenario.
module tb_fetch_stage;
    localparam logic [2:0] RTYPE = 3'd0;
    localparam logic [2:0] ITYPE = 3'd1;
    localparam logic [2:0] STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4;
    localparam logic [2:0] JTYPE = 3'd5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  typ;
        logic        ill;
    } got_t;

    logic clk = 1'b0;
    logic rst_i;
    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          gnt_cnt = 0;
    bit          mem_stall = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] gnt_log[$];
    got_t        got[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h2000 && a < 32'h2018) begin
            case (a[4:2])
                3'd0:    return 32'h00500093;
                3'd1:    return 32'h00112023;
                3'd2:    return 32'hFE000EE3;
                3'd3:    return 32'h000012B7;
                3'd4:    return 32'h0080006F;
                default: return 32'h0000007F;
            endcase
        end
        return {a[24:0], 7'b0010011};
    endfunction

    // Request/grant and delivery are observed mid-cycle, when they are stable.
    always @(negedge clk) begin
        if (bus.imem_req_o && bus.imem_gnt_i) begin
            pend.push_back(bus.imem_addr_o);
            gnt_log.push_back(bus.imem_addr_o);
            gnt_cnt++;
        end
        if (bus.id_valid_o && bus.id_ready_i)
            got.push_back('{bus.id_pc_o, bus.id_instr_o, bus.id_type_o, bus.id_illegal_o});
    end

    always @(posedge clk) begin
        #1;
        if (rst_i) begin
            pend.delete();
            bus.imem_rvalid_i = 1'b0;
        end else if (!mem_stall && pend.size() > 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(pend.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        gnt_cnt = 0;
        got.delete();
        gnt_log.delete();
    endtask

    task automatic wait_got(input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_tot++;
        if (got.size() < n) $display("FAIL wait_got: got %0d words, need %0d", got.size(), n);
        else n_pass++;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = pc;
        @(posedge clk); #1;
        bus.redirect_i = 1'b0;
        got.delete();
        gnt_log.delete();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tot++; if (bus.imem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req_o); else n_pass++;
        n_tot++; if (bus.imem_addr_o !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.imem_addr_o); else n_pass++;
        n_tot++; if (bus.id_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.id_valid_o); else n_pass++;
        n_tot++; if (bus.id_pc_o !== 32'h0) $display("FAIL rst_pc: got %h want 0", bus.id_pc_o); else n_pass++;
        n_tot++; if (bus.id_instr_o !== 32'h0) $display("FAIL rst_instr: got %h want 0", bus.id_instr_o); else n_pass++;
        n_tot++; if (bus.id_type_o !== RTYPE) $display("FAIL rst_type: got %0d want %0d", bus.id_type_o, RTYPE); else n_pass++;
        n_tot++; if (bus.id_illegal_o !== 1'b0) $display("FAIL rst_ill: got %b want 0", bus.id_illegal_o); else n_pass++;
    endtask

    task automatic test_stream();
        bus.id_ready_i = 1'b1;
        mem_stall = 1'b0;
        do_reset();
        @(negedge clk);
        n_tot++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0)
            $display("FAIL stream_c0: req %b addr %h want 1/0", bus.imem_req_o, bus.imem_addr_o); else n_pass++;
        @(negedge clk);
        n_tot++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4)
            $display("FAIL stream_c1: req %b addr %h want 1/4", bus.imem_req_o, bus.imem_addr_o); else n_pass++;
        @(negedge clk);
        n_tot++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h0)
            $display("FAIL stream_lat: valid %b pc %h want 1/0", bus.id_valid_o, bus.id_pc_o); else n_pass++;
        wait_got(8, 60);
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_tot++;
            if (got[i].pc !== 32'(4*i) || got[i].instr !== mem_word(32'(4*i)))
                $display("FAIL stream_seq[%0d]: pc %h instr %h want %h %h", i, got[i].pc, got[i].instr,
                         32'(4*i), mem_word(32'(4*i)));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bus.id_ready_i = 1'b0;
        mem_stall = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2 && (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h0)) bad++;
        end
        n_tot++; if (gnt_cnt !== 2) $display("FAIL bp_grants: got %0d want 2", gnt_cnt); else n_pass++;
        n_tot++; if (bad !== 0) $display("FAIL bp_hold: %0d cycles head not pc 0", bad); else n_pass++;
        @(posedge clk); #1;
        bus.id_ready_i = 1'b1;
        wait_got(6, 40);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_tot++;
            if (got[i].pc !== 32'(4*i)) $display("FAIL bp_seq[%0d]: pc %h want %h", i, got[i].pc, 32'(4*i));
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        bus.id_ready_i = 1'b1;
        mem_stall = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        n_tot++; if (gnt_cnt !== 2) $display("FAIL rd_inflight: got %0d want 2", gnt_cnt); else n_pass++;
        @(posedge clk); #1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h1002;
        @(negedge clk);
        n_tot++; if (bus.imem_req_o !== 1'b0) $display("FAIL rd_req_low: got %b want 0", bus.imem_req_o); else n_pass++;
        @(posedge clk); #1;
        bus.redirect_i = 1'b0;
        got.delete();
        @(negedge clk);
        n_tot++; if (bus.imem_addr_o !== 32'h1000 || bus.id_valid_o !== 1'b0)
            $display("FAIL rd_addr: addr %h valid %b want 1000/0", bus.imem_addr_o, bus.id_valid_o); else n_pass++;
        @(posedge clk); #1;
        mem_stall = 1'b0;
        wait_got(2, 40);
        if (got.size() >= 2) begin
            n_tot++;
            if (got[0].pc !== 32'h1000 || got[0].instr !== mem_word(32'h1000))
                $display("FAIL rd_first: pc %h instr %h want 1000 %h", got[0].pc, got[0].instr, mem_word(32'h1000));
            else n_pass++;
            n_tot++;
            if (got[1].pc !== 32'h1004) $display("FAIL rd_second: pc %h want 1004", got[1].pc); else n_pass++;
        end
    endtask

    task automatic test_predecode();
        logic [2:0] exp_t [6];
        logic       exp_i [6];
        exp_t = '{ITYPE, STYPE, BTYPE, UTYPE, JTYPE, RTYPE};
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.id_ready_i = 1'b1;
        mem_stall = 1'b0;
        do_redirect(32'h2000);
        wait_got(6, 40);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_tot++;
            if (got[i].typ !== exp_t[i]) $display("FAIL pd_type[%0d]: got %0d want %0d", i, got[i].typ, exp_t[i]);
            else n_pass++;
            n_tot++;
            if (got[i].ill !== exp_i[i]) $display("FAIL pd_ill[%0d]: got %b want %b", i, got[i].ill, exp_i[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bus.id_ready_i = 1'b1;
        mem_stall = 1'b0;
        do_redirect(32'hFFFF_FFFC);
        wait_got(2, 40);
        if (got.size() >= 2 && gnt_log.size() >= 2) begin
            n_tot++;
            if (gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0)
                $display("FAIL wrap_addr: %h %h want fffffffc 0", gnt_log[0], gnt_log[1]);
            else n_pass++;
            n_tot++;
            if (got[0].pc !== 32'hFFFF_FFFC || got[1].pc !== 32'h0)
                $display("FAIL wrap_pc: %h %h want fffffffc 0", got[0].pc, got[1].pc);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bus.id_ready_i = 1'b1;
        @(posedge clk); #1;
        mem_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tot++; if (bus.id_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0)
            $display("FAIL mid_rst_ctl: valid %b req %b want 0/0", bus.id_valid_o, bus.imem_req_o); else n_pass++;
        n_tot++; if (bus.imem_addr_o !== 32'h0 || bus.id_pc_o !== 32'h0 || bus.id_instr_o !== 32'h0)
            $display("FAIL mid_rst_data: addr %h pc %h instr %h want 0", bus.imem_addr_o, bus.id_pc_o, bus.id_instr_o);
        else n_pass++;
        @(posedge clk); #1;
        rst_i = 1'b0;
        mem_stall = 1'b0;
        got.delete();
        gnt_log.delete();
        wait_got(3, 40);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_tot++;
            if (got[i].pc !== 32'(4*i)) $display("FAIL mid_seq[%0d]: pc %h want %h", i, got[i].pc, 32'(4*i));
            else n_pass++;
        end
    endtask

    initial begin
        rst_i             = 1'b1;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.id_ready_i    = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_predecode();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
